// File: rtl/hazard_unit_if.sv
// ID-stage hazard interface: ID publishes operand/destination info, the hazard unit answers with
// stall, flush and forwarding controls.
interface hazard_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic [4:0]       id_rd_addr;
  logic [4:0]       id_opcode;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             ex_redirect;
  logic             stall_pc;
  logic             stall_if_id;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_opcode, id_reg_write,
           id_mem_read, ex_redirect,
    input  stall_pc, stall_if_id, flush_if_id, flush_id_ex, fwd_a_sel, fwd_b_sel, stall_count
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_opcode, id_reg_write,
           id_mem_read, ex_redirect,
    output stall_pc, stall_if_id, flush_if_id, flush_id_ex, fwd_a_sel, fwd_b_sel, stall_count
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: EX/MEM/WB destination scoreboard, stall/flush decisions and forwarding.
// Define HAZARD_FORWARD_EN to enable operand forwarding (only load-use then stalls).
module hazard_unit #(
  parameter int unsigned CNT_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  hazard_unit_if.slave bus
);

  localparam logic [4:0] OpLui    = 5'b01101;
  localparam logic [4:0] OpAuipc  = 5'b00101;
  localparam logic [4:0] OpJal    = 5'b11011;
  localparam logic [4:0] OpOp     = 5'b01100;
  localparam logic [4:0] OpStore  = 5'b01000;
  localparam logic [4:0] OpBranch = 5'b11000;

  // Scoreboard slots
  logic       r_ex_valid;
  logic [4:0] r_ex_rd;
  logic       r_mem_valid;
  logic [4:0] r_mem_rd;
  logic       r_wb_valid;
  logic [4:0] r_wb_rd;

  logic       w_use_rs1;
  logic       w_use_rs2;
  logic       w_a_ex;
  logic       w_b_ex;
  logic       w_a_mem;
  logic       w_b_mem;
  logic       w_hazard;
  logic       w_stall;
  logic       w_issue;
  logic       w_new_valid;

  logic [CNT_W-1:0] r_stall_count;

  always_comb begin
    w_use_rs1 = !((bus.id_opcode == OpLui) || (bus.id_opcode == OpAuipc) ||
                  (bus.id_opcode == OpJal));
    w_use_rs2 = (bus.id_opcode == OpOp) || (bus.id_opcode == OpStore) ||
                (bus.id_opcode == OpBranch);
    w_a_ex    = w_use_rs1 && r_ex_valid  && (r_ex_rd  == bus.id_rs1_addr);
    w_b_ex    = w_use_rs2 && r_ex_valid  && (r_ex_rd  == bus.id_rs2_addr);
    w_a_mem   = w_use_rs1 && r_mem_valid && (r_mem_rd == bus.id_rs1_addr);
    w_b_mem   = w_use_rs2 && r_mem_valid && (r_mem_rd == bus.id_rs2_addr);
  end

`ifdef HAZARD_FORWARD_EN
  logic       r_ex_load;
  logic [1:0] r_fwd_a_sel;
  logic [1:0] r_fwd_b_sel;

  assign w_hazard = (w_a_ex || w_b_ex) && r_ex_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_load   <= 1'b0;
      r_fwd_a_sel <= 2'b00;
      r_fwd_b_sel <= 2'b00;
    end else begin
      r_ex_load <= w_issue && bus.id_mem_read;
      if (w_issue) begin
        // Youngest producer (EX) wins when both slots hold the register
        r_fwd_a_sel <= w_a_ex ? 2'b01 : (w_a_mem ? 2'b10 : 2'b00);
        r_fwd_b_sel <= w_b_ex ? 2'b01 : (w_b_mem ? 2'b10 : 2'b00);
      end else begin
        r_fwd_a_sel <= 2'b00;
        r_fwd_b_sel <= 2'b00;
      end
    end
  end

  assign bus.fwd_a_sel = r_fwd_a_sel;
  assign bus.fwd_b_sel = r_fwd_b_sel;
`else
  logic w_unused_mem_read;

  assign w_hazard          = w_a_ex || w_b_ex || w_a_mem || w_b_mem;
  assign w_unused_mem_read = bus.id_mem_read;
  assign bus.fwd_a_sel     = 2'b00;
  assign bus.fwd_b_sel     = 2'b00;
`endif

  // Redirect wins: the ID instruction is wrong-path, so it is flushed rather than held
  assign w_stall     = bus.id_valid && w_hazard && !bus.ex_redirect;
  assign w_issue     = bus.id_valid && !w_stall && !bus.ex_redirect;
  assign w_new_valid = w_issue && bus.id_reg_write && (bus.id_rd_addr != 5'd0);

  assign bus.stall_pc    = w_stall;
  assign bus.stall_if_id = w_stall;
  assign bus.flush_if_id = bus.ex_redirect;
  assign bus.flush_id_ex = w_stall || bus.ex_redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_valid    <= 1'b0;
      r_ex_rd       <= 5'd0;
      r_mem_valid   <= 1'b0;
      r_mem_rd      <= 5'd0;
      r_wb_valid    <= 1'b0;
      r_wb_rd       <= 5'd0;
      r_stall_count <= '0;
    end else begin
      r_wb_valid  <= r_mem_valid;
      r_wb_rd     <= r_mem_rd;
      r_mem_valid <= r_ex_valid;
      r_mem_rd    <= r_ex_rd;
      r_ex_valid  <= w_new_valid;
      r_ex_rd     <= w_issue ? bus.id_rd_addr : 5'd0;
      if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

  // Register file writes through to same-cycle reads, so the WB entry never gates anything
  logic w_unused_wb;
  assign w_unused_wb = ^{r_wb_valid, r_wb_rd};

  assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized scoreboard bench for hazard_unit against an instruction-level reference model.
module tb_hazard_unit;

  localparam int unsigned CntW   = 4;
  localparam int          CntMax = (1 << CntW) - 1;
`ifdef HAZARD_FORWARD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  localparam logic [4:0] OpLoad   = 5'b00000;
  localparam logic [4:0] OpImm    = 5'b00100;
  localparam logic [4:0] OpAuipc  = 5'b00101;
  localparam logic [4:0] OpStore  = 5'b01000;
  localparam logic [4:0] OpOp     = 5'b01100;
  localparam logic [4:0] OpLui    = 5'b01101;
  localparam logic [4:0] OpBranch = 5'b11000;
  localparam logic [4:0] OpJalr   = 5'b11001;
  localparam logic [4:0] OpJal    = 5'b11011;

  typedef struct {
    bit       spc;
    bit       sif;
    bit       fif;
    bit       fie;
    bit [1:0] fa;
    bit [1:0] fb;
    int       cnt;
  } exp_t;

  typedef struct {
    bit       w;
    bit [4:0] rd;
    bit       ld;
  } slot_t;

  logic clk;
  logic reset;
  hazard_unit_if #(.CNT_W(CntW)) bus ();

  hazard_unit #(.CNT_W(CntW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t  q[$];
  int    total = 0;
  int    bad   = 0;

  // Reference model: last three issued instructions, youngest first
  slot_t m_pipe[3];
  bit [1:0] m_fa, m_fb;
  int    m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_pipe[i] = '{w: 1'b0, rd: 5'd0, ld: 1'b0};
    m_fa  = 2'b00;
    m_fb  = 2'b00;
    m_cnt = 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("stall_pc",    int'(bus.stall_pc),    int'(e.spc));
      check("stall_if_id", int'(bus.stall_if_id), int'(e.sif));
      check("flush_if_id", int'(bus.flush_if_id), int'(e.fif));
      check("flush_id_ex", int'(bus.flush_id_ex), int'(e.fie));
      check("fwd_a_sel",   int'(bus.fwd_a_sel),   int'(e.fa));
      check("fwd_b_sel",   int'(bus.fwd_b_sel),   int'(e.fb));
      check("stall_count", int'(bus.stall_count), e.cnt);
    end
  end

  task automatic cycle(input bit v, input logic [4:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input bit rw,
                       input bit mr, input bit redir, input bit rst, output bit st);
    bit   use1, use2, m1[2], m2[2], haz, stall, issue;
    exp_t e;
    @(posedge clk);
    #1;
    bus.id_valid     = v;
    bus.id_opcode    = op;
    bus.id_rs1_addr  = rs1;
    bus.id_rs2_addr  = rs2;
    bus.id_rd_addr   = rd;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.ex_redirect  = redir;
    reset            = rst;
    if (rst) model_reset();

    use1 = !(op inside {OpLui, OpAuipc, OpJal});
    use2 = op inside {OpOp, OpStore, OpBranch};
    for (int s = 0; s < 2; s++) begin
      m1[s] = use1 && m_pipe[s].w && (m_pipe[s].rd == rs1);
      m2[s] = use2 && m_pipe[s].w && (m_pipe[s].rd == rs2);
    end
    if (Fwd) haz = (m1[0] || m2[0]) && m_pipe[0].ld;
    else     haz = m1[0] || m2[0] || m1[1] || m2[1];
    stall = v && haz && !redir;
    issue = v && !stall && !redir;

    e.spc = stall;
    e.sif = stall;
    e.fif = redir;
    e.fie = stall || redir;
    e.fa  = m_fa;
    e.fb  = m_fb;
    e.cnt = m_cnt;
    q.push_back(e);
    st = stall;

    if (!rst) begin
      if (stall && m_cnt < CntMax) m_cnt++;
      if (Fwd && issue) begin
        m_fa = m1[0] ? 2'd1 : (m1[1] ? 2'd2 : 2'd0);
        m_fb = m2[0] ? 2'd1 : (m2[1] ? 2'd2 : 2'd0);
      end else begin
        m_fa = 2'd0;
        m_fb = 2'd0;
      end
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0].w  = issue && rw && (rd != 5'd0);
      m_pipe[0].rd = issue ? rd : 5'd0;
      m_pipe[0].ld = issue && mr;
    end
  endtask

  task automatic idle(input int n);
    bit st;
    for (int i = 0; i < n; i++) cycle(0, OpImm, 0, 0, 0, 0, 0, 0, 0, st);
  endtask

  // Issue the consumer, holding it in ID for as long as the model says it stalls
  task automatic consume(input logic [4:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd);
    bit st;
    st = 1'b1;
    for (int i = 0; i < 4 && st; i++) cycle(1, op, rs1, rs2, rd, 1, 0, 0, 0, st);
  endtask

  initial begin
    bit st;
    reset = 1'b1;
    bus.id_valid = 0; bus.id_opcode = 0; bus.id_rs1_addr = 0; bus.id_rs2_addr = 0;
    bus.id_rd_addr = 0; bus.id_reg_write = 0; bus.id_mem_read = 0; bus.ex_redirect = 0;
    model_reset();
    cycle(0, OpImm, 0, 0, 0, 0, 0, 0, 1, st);
    idle(2);

    // Reset while a RAW stall is pending
    cycle(1, OpImm, 0, 0, 5, 1, 0, 0, 0, st);
    cycle(1, OpOp, 5, 5, 6, 1, 0, 0, 0, st);
    cycle(1, OpOp, 5, 5, 6, 1, 0, 0, 1, st);
    cycle(1, OpOp, 5, 5, 6, 1, 0, 0, 0, st);
    idle(3);
    cycle(0, OpImm, 0, 0, 0, 0, 0, 0, 1, st);

    // lw x5,0(x1); add x6,x5,x2
    cycle(1, OpLoad, 1, 0, 5, 1, 1, 0, 0, st);
    consume(OpOp, 5, 2, 6);
    idle(3);
    // addi x5,x0,1; add x6,x5,x5
    cycle(1, OpImm, 0, 1, 5, 1, 0, 0, 0, st);
    consume(OpOp, 5, 5, 6);
    idle(3);
    // x0 producer, then lui x5 feeding jal bits
    cycle(1, OpImm, 0, 1, 0, 1, 0, 0, 0, st);
    consume(OpOp, 0, 0, 6);
    cycle(1, OpLui, 0, 0, 5, 1, 0, 0, 0, st);
    consume(OpJal, 5, 5, 1);
    idle(3);
    // Redirect over a load-use consumer
    cycle(1, OpLoad, 1, 0, 5, 1, 1, 0, 0, st);
    cycle(1, OpOp, 5, 2, 6, 1, 0, 1, 0, st);
    consume(OpOp, 5, 2, 6);
    idle(3);

    // Saturate the counter
    cycle(0, OpImm, 0, 0, 0, 0, 0, 0, 1, st);
    for (int i = 0; i < 20; i++) begin
      cycle(1, OpLoad, 1, 0, 7, 1, 1, 0, 0, st);
      consume(OpOp, 7, 7, 8);
    end
    idle(3);

    // Random traffic on a narrow register range to provoke hazards
    cycle(0, OpImm, 0, 0, 0, 0, 0, 0, 1, st);
    for (int i = 0; i < 600; i++) begin
      logic [4:0] ops[9];
      logic [4:0] op;
      bit         rst, rdr;
      ops = '{OpLoad, OpImm, OpAuipc, OpStore, OpOp, OpLui, OpBranch, OpJalr, OpJal};
      op  = ops[$urandom_range(0, 8)];
      rst = ($urandom_range(0, 99) == 0);
      rdr = !rst && ($urandom_range(0, 7) == 0);
      cycle(($urandom_range(0, 7) != 0), op, 5'($urandom_range(0, 5)),
            5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), ($urandom_range(0, 3) != 0),
            (op == OpLoad), rdr, rst, st);
    end

    @(posedge clk);
    repeat (2) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
